key_debounce_multi: RTL and testbench
=====================================

Name: key_debounce_multi

Overview:
- Parametrised multi-channel push-key conditioner; successor to the single-key debouncer.
- Per channel: synchronises a raw mechanical key, debounces it and presents a clean pressed level.
- Also generates one-cycle press, release and long-press pulses.
- Sits between board key pins and control logic (menus, mode select); one instance serves a whole key bank.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DB_CYCLES, 1000000, cycles a new level must hold before acceptance (20 ms at 50 MHz); minimum 2.
- LONG_CYCLES, 50000000, cycles held pressed before long_press fires (1 s at 50 MHz); 0 disables long-press.
- ACTIVE_LOW, 1, 1 means a pressed key reads 0 (idle pin high); 0 means a pressed key reads 1.

Ports:
- clk  in  1  system clock (50 MHz nominal).
- rst  in  1  asynchronous active-high reset.
- key  in  N_KEYS  raw asynchronous key pins.
- pressed  out  N_KEYS  debounced level, 1 = pressed, regardless of ACTIVE_LOW.
- press  out  N_KEYS  one-cycle pulse on an accepted press.
- release  out  N_KEYS  one-cycle pulse on an accepted release.
- long_press  out  N_KEYS  one-cycle pulse, at most once per press.

Behaviour:
- Reset is asynchronous and active-high, on a single clock domain.
- While rst is high, all outputs are 0.
- Synchroniser flops reset to the idle pin level (ACTIVE_LOW ? 1 : 0), so no spurious event occurs after reset release.
- Per channel, key passes through a 2-flop synchroniser. The second flop's output s, converted to pressed-polarity, is sample p.
- Debounce counter dcnt is $clog2(DB_CYCLES) bits wide and resets to 0. Each cycle:
  - If p == pressed: dcnt <= 0.
  - Else if dcnt == DB_CYCLES-1: pressed <= p, dcnt <= 0, and the press or release pulse is asserted in that same cycle.
  - Else: dcnt <= dcnt+1.
- Latency: a clean edge on key appears on pressed DB_CYCLES+2 rising edges after the first edge that samples the new level.
- Any bounce back to the current level before acceptance clears dcnt. Acceptance therefore requires DB_CYCLES consecutive differing samples.
- A pulse shorter than DB_CYCLES produces no output change.
- press and release are registered, high for exactly one cycle, and mutually exclusive per channel.
- Long-press counter lcnt is $clog2(LONG_CYCLES+1) bits wide, is cleared while pressed == 0, and clears on the press-accept cycle.
- While pressed == 1 and lcnt < LONG_CYCLES, lcnt increments.
- When lcnt reaches LONG_CYCLES-1 and increments to LONG_CYCLES, long_press pulses for one cycle. lcnt then saturates, so there is no repeat until after a release.
- long_press is measured from press acceptance, not from the raw edge.
- If the key is released before LONG_CYCLES, no long_press is generated.
- When LONG_CYCLES == 0, long_press is tied 0 and the lcnt logic is removed.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- Reset mid-count discards the count. After release, the channel reports released, even if the key is physically held.
  - If the key stays held through reset release, a press is accepted DB_CYCLES+2 cycles later.
  - This is intended: it is the power-on-hold case.
- The counters never wrap: dcnt is bounded by DB_CYCLES-1 and lcnt saturates.

Decomposition:
- Shared package (key_pkg): function for the idle pin level from ACTIVE_LOW, and the counter-width helpers used by the counters.
- No typedefs are required.
- Sub-module key_debounce_ch holds one channel: synchroniser, dcnt, lcnt, pressed and the pulse flops.
- The top is a generate loop over N_KEYS that passes the parameters through.

Test Plan (all with N_KEYS=2, DB_CYCLES=16, LONG_CYCLES=100, ACTIVE_LOW=1, 20 ns clock):
- Reset and idle: assert rst for 5 cycles with key=2'b11, then release and hold for 200 cycles -> all outputs 0 throughout, and no pulses.
- Clean press on ch0: key[0] 1->0 and held -> pressed[0] rises exactly 18 edges later, press[0] pulses 1 cycle in that same cycle, ch1 stays quiet.
- Bounce rejection on ch0: key[0] toggles with random 1-15 cycle widths for 50 toggles, then settles to 0 -> exactly one press[0], 18 cycles after the final edge, and no release[0].
- Short glitch: key[1] low for 15 cycles -> no change on ch1; low for 16 cycles -> one press[1], then one release[1] 18 cycles after return high.
- Long press on ch0: hold pressed 300 cycles -> long_press[0] exactly once, 100 cycles after pressed[0] rose; on release, release[0] follows once; hold only 50 cycles -> no long_press.
- Async reset mid-operation: assert rst while ch0 is pressed and lcnt=50 -> outputs drop to 0 immediately, without waiting for a clock edge; key still held after rst release -> press[0] re-fires 18 cycles later, and long_press[0] fires 100 cycles after that.

Source files
------------

// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared helpers for the multi-channel key conditioner.
//   idleLevel  : pin level of a key that is not being pressed
//   dcntWidth  : width of the debounce counter for a given hold time
//   lcntWidth  : width of the long-press counter, which must be able to
//                hold the terminal value itself because it saturates there
// ---------------------------------------------------------------------------
package key_pkg;

  // An active-low key idles high, an active-high key idles low.
  function automatic logic idleLevel(input int activeLow);
    return (activeLow != 0) ? 1'b1 : 1'b0;
  endfunction

  // The debounce counter never exceeds dbCycles-1, so $clog2(dbCycles) bits
  // suffice. Keep at least one bit so the vector is always legal.
  function automatic int dcntWidth(input int dbCycles);
    int w;
    w = $clog2(dbCycles);
    return (w < 1) ? 1 : w;
  endfunction

  // The long-press counter parks on longCycles, so it needs one extra code.
  function automatic int lcntWidth(input int longCycles);
    int w;
    w = $clog2(longCycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// ---------------------------------------------------------------------------
// key_debounce_ch
// One key channel: two-flop synchroniser, debounce counter, clean pressed
// level and the registered press / release / long_press pulses.
//
// Ports
//   i_clk         system clock
//   i_rst         asynchronous active-high reset
//   i_key         raw asynchronous key pin
//   o_pressed     debounced level, 1 = pressed regardless of pin polarity
//   o_press       one-cycle pulse when a press is accepted
//   o_release     one-cycle pulse when a release is accepted
//   o_long_press  one-cycle pulse after LONG_CYCLES of accepted press
// ---------------------------------------------------------------------------
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DB_CYCLES   = 1000000,
  parameter int LONG_CYCLES = 50000000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_pressed,
  output logic o_press,
  output logic o_release,
  output logic o_long_press
);

  localparam int              DW        = dcntWidth(DB_CYCLES);
  localparam logic            IDLE      = idleLevel(ACTIVE_LOW);
  localparam logic [DW-1:0]   DCNT_LAST = DW'(DB_CYCLES - 1);
  localparam logic [DW-1:0]   DCNT_ONE  = DW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic [DW-1:0] r_dcnt;
  logic          r_pressed;
  logic          r_pressPulse;
  logic          r_releasePulse;
  logic          w_sample;

  // Synchroniser. Both flops reset to the idle pin level so that leaving
  // reset with an untouched key never looks like an edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= IDLE;
      r_sync2 <= IDLE;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  // Convert the synchronised pin to pressed-polarity (1 = pressed).
  assign w_sample = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  // Debouncer. Any sample matching the current level restarts the count, so
  // a new level is accepted only after DB_CYCLES consecutive differing
  // samples. The pulse flops are written in the same cycle as r_pressed so
  // that press/release line up exactly with the level change.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dcnt         <= '0;
      r_pressed      <= 1'b0;
      r_pressPulse   <= 1'b0;
      r_releasePulse <= 1'b0;
    end else begin
      r_pressPulse   <= 1'b0;
      r_releasePulse <= 1'b0;
      if (w_sample == r_pressed) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DCNT_LAST) begin
        r_pressed      <= w_sample;
        r_dcnt         <= '0;
        r_pressPulse   <= w_sample;
        r_releasePulse <= ~w_sample;
      end else begin
        r_dcnt <= r_dcnt + DCNT_ONE;
      end
    end
  end

  assign o_pressed = r_pressed;
  assign o_press   = r_pressPulse;
  assign o_release = r_releasePulse;

  // Long-press detection only exists when LONG_CYCLES is non-zero.
  generate
    if (LONG_CYCLES > 0) begin : genLong
      localparam int            LW        = lcntWidth(LONG_CYCLES);
      localparam logic [LW-1:0] LCNT_MAX  = LW'(LONG_CYCLES);
      localparam logic [LW-1:0] LCNT_PRE  = LW'(LONG_CYCLES - 1);
      localparam logic [LW-1:0] LCNT_ONE  = LW'(1);

      logic [LW-1:0] r_lcnt;
      logic          r_longPulse;

      // The counter is held at zero while released, which includes the
      // accept cycle itself, so timing starts from the accepted press.
      // It parks on LCNT_MAX, giving at most one pulse per press.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_lcnt      <= '0;
          r_longPulse <= 1'b0;
        end else begin
          r_longPulse <= 1'b0;
          if (!r_pressed) begin
            r_lcnt <= '0;
          end else if (r_lcnt < LCNT_MAX) begin
            r_lcnt <= r_lcnt + LCNT_ONE;
            if (r_lcnt == LCNT_PRE) begin
              r_longPulse <= 1'b1;
            end
          end
        end
      end

      assign o_long_press = r_longPulse;
    end else begin : genNoLong
      assign o_long_press = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/key_debounce_multi.sv
// ---------------------------------------------------------------------------
// key_debounce_multi
// Multi-channel push-key conditioner. Each bit of i_key gets its own fully
// independent key_debounce_ch instance.
//
// Ports
//   i_clk         system clock
//   i_rst         asynchronous active-high reset
//   i_key         raw asynchronous key pins, one per channel
//   o_pressed     debounced levels, 1 = pressed
//   o_press       one-cycle pulses on accepted presses
//   o_release     one-cycle pulses on accepted releases
//   o_long_press  one-cycle pulses, at most once per press
// ---------------------------------------------------------------------------
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int N_KEYS      = 4,
  parameter int DB_CYCLES   = 1000000,
  parameter int LONG_CYCLES = 50000000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_pressed,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long_press
);

  // One channel per key; no state is shared between channels.
  generate
    for (genvar g = 0; g < N_KEYS; g++) begin : genCh
      key_debounce_ch #(
        .DB_CYCLES   (DB_CYCLES),
        .LONG_CYCLES (LONG_CYCLES),
        .ACTIVE_LOW  (ACTIVE_LOW)
      ) uCh (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_key        (i_key[g]),
        .o_pressed    (o_pressed[g]),
        .o_press      (o_press[g]),
        .o_release    (o_release[g]),
        .o_long_press (o_long_press[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce_multi.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_multi
// Directed bench for key_debounce_multi with two active-low keys,
// DB_CYCLES=16 and LONG_CYCLES=100. Inputs are driven on the falling edge
// and outputs sampled on the falling edge; cycle numbers count rising edges
// since the last clearStats call, so a clean edge shows up at cycle 18.
// ---------------------------------------------------------------------------
module tb_key_debounce_multi;

  localparam int N_KEYS      = 2;
  localparam int DB_CYCLES   = 16;
  localparam int LONG_CYCLES = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_KEYS-1:0] key = 2'b11;
  logic [N_KEYS-1:0] pressed;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] rel;
  logic [N_KEYS-1:0] longp;

  int checks   = 0;
  int failures = 0;

  int   cyc;
  int   pressCnt [N_KEYS];
  int   pressAt  [N_KEYS];
  int   relCnt   [N_KEYS];
  int   relAt    [N_KEYS];
  int   longCnt  [N_KEYS];
  int   longAt   [N_KEYS];
  int   riseAt   [N_KEYS];
  logic act      [N_KEYS];
  logic prevPr   [N_KEYS];

  key_debounce_multi #(
    .N_KEYS      (N_KEYS),
    .DB_CYCLES   (DB_CYCLES),
    .LONG_CYCLES (LONG_CYCLES),
    .ACTIVE_LOW  (1)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_key        (key),
    .o_pressed    (pressed),
    .o_press      (press),
    .o_release    (rel),
    .o_long_press (longp)
  );

  // 20 ns clock.
  always #10 clk = ~clk;

  // Restart the event log; cycle numbers are relative to this call.
  task automatic clearStats();
    cyc = 0;
    for (int ch = 0; ch < N_KEYS; ch++) begin
      pressCnt[ch] = 0;  pressAt[ch] = -1;
      relCnt[ch]   = 0;  relAt[ch]   = -1;
      longCnt[ch]  = 0;  longAt[ch]  = -1;
      riseAt[ch]   = -1;
      act[ch]      = 1'b0;
      prevPr[ch]   = pressed[ch];
    end
  endtask

  // Advance n clocks, logging every output event seen at the falling edge.
  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      for (int ch = 0; ch < N_KEYS; ch++) begin
        if (press[ch]) begin pressCnt[ch]++; pressAt[ch] = cyc; end
        if (rel[ch])   begin relCnt[ch]++;   relAt[ch]   = cyc; end
        if (longp[ch]) begin longCnt[ch]++;  longAt[ch]  = cyc; end
        if (pressed[ch] && !prevPr[ch] && riseAt[ch] < 0) riseAt[ch] = cyc;
        prevPr[ch] = pressed[ch];
        if (pressed[ch] || press[ch] || rel[ch] || longp[ch]) act[ch] = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b1;
    key = 2'b11;
    clearStats();
    stepCycles(5);
    checks++;
    if (act[0] !== 1'b0 || act[1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_quiet act0=%0b act1=%0b expected 0 0", act[0], act[1]);
    end
    checks++;
    if ({pressed, press, rel, longp} !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h expected 00", {pressed, press, rel, longp});
    end
    rst = 1'b0;
    clearStats();
    stepCycles(200);
    checks++;
    if (act[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_ch0 activity=%0b expected 0", act[0]);
    end
    checks++;
    if (act[1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_ch1 activity=%0b expected 0", act[1]);
    end
  endtask

  task automatic test_clean_press();
    $display("[TB] test_clean_press");
    key[0] = 1'b0;
    clearStats();
    stepCycles(30);
    checks++;
    if (riseAt[0] !== 18) begin
      failures++;
      $display("[TB] FAIL clean_rise got=%0d expected 18", riseAt[0]);
    end
    checks++;
    if (pressCnt[0] !== 1 || pressAt[0] !== 18) begin
      failures++;
      $display("[TB] FAIL clean_press count=%0d at=%0d expected 1 at 18", pressCnt[0], pressAt[0]);
    end
    checks++;
    if (relCnt[0] !== 0) begin
      failures++;
      $display("[TB] FAIL clean_no_release got=%0d expected 0", relCnt[0]);
    end
    checks++;
    if (act[1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clean_ch1_quiet activity=%0b expected 0", act[1]);
    end
    key[0] = 1'b1;
    clearStats();
    stepCycles(30);
    checks++;
    if (relCnt[0] !== 1 || relAt[0] !== 18) begin
      failures++;
      $display("[TB] FAIL clean_release count=%0d at=%0d expected 1 at 18", relCnt[0], relAt[0]);
    end
    checks++;
    if (pressed[0] !== 1'b0 || longCnt[0] !== 0) begin
      failures++;
      $display("[TB] FAIL clean_after_release pressed=%0b long=%0d expected 0 0", pressed[0], longCnt[0]);
    end
  endtask

  task automatic test_bounce();
    logic lvl;
    $display("[TB] test_bounce");
    lvl = 1'b1;
    clearStats();
    for (int i = 0; i < 50; i++) begin
      lvl    = ~lvl;
      key[0] = lvl;
      stepCycles(int'($urandom_range(15, 1)));
    end
    checks++;
    if (pressCnt[0] !== 0 || relCnt[0] !== 0 || pressed[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bounce_rejected press=%0d release=%0d pressed=%0b expected 0 0 0",
               pressCnt[0], relCnt[0], pressed[0]);
    end
    key[0] = 1'b0;
    clearStats();
    stepCycles(40);
    checks++;
    if (pressCnt[0] !== 1 || pressAt[0] !== 18) begin
      failures++;
      $display("[TB] FAIL bounce_settle_press count=%0d at=%0d expected 1 at 18", pressCnt[0], pressAt[0]);
    end
    checks++;
    if (relCnt[0] !== 0) begin
      failures++;
      $display("[TB] FAIL bounce_no_release got=%0d expected 0", relCnt[0]);
    end
    key[0] = 1'b1;
    clearStats();
    stepCycles(40);
    checks++;
    if (relCnt[0] !== 1) begin
      failures++;
      $display("[TB] FAIL bounce_final_release got=%0d expected 1", relCnt[0]);
    end
  endtask

  task automatic test_glitch();
    $display("[TB] test_glitch");
    key[1] = 1'b0;
    clearStats();
    stepCycles(15);
    key[1] = 1'b1;
    stepCycles(30);
    checks++;
    if (act[1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL glitch15_ignored activity=%0b press=%0d expected 0 0", act[1], pressCnt[1]);
    end
    key[1] = 1'b0;
    clearStats();
    stepCycles(16);
    key[1] = 1'b1;
    stepCycles(30);
    checks++;
    if (pressCnt[1] !== 1 || pressAt[1] !== 18) begin
      failures++;
      $display("[TB] FAIL glitch16_press count=%0d at=%0d expected 1 at 18", pressCnt[1], pressAt[1]);
    end
    checks++;
    if (relCnt[1] !== 1 || relAt[1] !== 34) begin
      failures++;
      $display("[TB] FAIL glitch16_release count=%0d at=%0d expected 1 at 34", relCnt[1], relAt[1]);
    end
    checks++;
    if (act[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL glitch_ch0_quiet activity=%0b expected 0", act[0]);
    end
  endtask

  task automatic test_long_press();
    $display("[TB] test_long_press");
    key[0] = 1'b0;
    clearStats();
    stepCycles(300);
    checks++;
    if (riseAt[0] !== 18) begin
      failures++;
      $display("[TB] FAIL long_rise got=%0d expected 18", riseAt[0]);
    end
    checks++;
    if (longCnt[0] !== 1 || longAt[0] !== 118) begin
      failures++;
      $display("[TB] FAIL long_pulse count=%0d at=%0d expected 1 at 118", longCnt[0], longAt[0]);
    end
    checks++;
    if (relCnt[0] !== 0 || pressCnt[0] !== 1) begin
      failures++;
      $display("[TB] FAIL long_held release=%0d press=%0d expected 0 1", relCnt[0], pressCnt[0]);
    end
    key[0] = 1'b1;
    clearStats();
    stepCycles(30);
    checks++;
    if (relCnt[0] !== 1 || relAt[0] !== 18 || longCnt[0] !== 0) begin
      failures++;
      $display("[TB] FAIL long_release count=%0d at=%0d long=%0d expected 1 at 18 long 0",
               relCnt[0], relAt[0], longCnt[0]);
    end
    key[0] = 1'b0;
    clearStats();
    stepCycles(50);
    key[0] = 1'b1;
    stepCycles(40);
    checks++;
    if (longCnt[0] !== 0) begin
      failures++;
      $display("[TB] FAIL short_hold_no_long got=%0d expected 0", longCnt[0]);
    end
    checks++;
    if (pressCnt[0] !== 1 || relCnt[0] !== 1 || relAt[0] !== 68) begin
      failures++;
      $display("[TB] FAIL short_hold_events press=%0d release=%0d at=%0d expected 1 1 at 68",
               pressCnt[0], relCnt[0], relAt[0]);
    end
  endtask

  task automatic test_async_reset();
    $display("[TB] test_async_reset");
    key[0] = 1'b0;
    clearStats();
    stepCycles(68);
    checks++;
    if (pressed[0] !== 1'b1 || riseAt[0] !== 18 || longCnt[0] !== 0) begin
      failures++;
      $display("[TB] FAIL arst_pre pressed=%0b rise=%0d long=%0d expected 1 18 0",
               pressed[0], riseAt[0], longCnt[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({pressed, press, rel, longp} !== 8'h00) begin
      failures++;
      $display("[TB] FAIL arst_immediate got=%h expected 00", {pressed, press, rel, longp});
    end
    clearStats();
    stepCycles(3);
    checks++;
    if (act[0] !== 1'b0 || act[1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL arst_held act0=%0b act1=%0b expected 0 0", act[0], act[1]);
    end
    rst = 1'b0;
    clearStats();
    stepCycles(130);
    checks++;
    if (pressCnt[0] !== 1 || pressAt[0] !== 18) begin
      failures++;
      $display("[TB] FAIL arst_repress count=%0d at=%0d expected 1 at 18", pressCnt[0], pressAt[0]);
    end
    checks++;
    if (longCnt[0] !== 1 || longAt[0] !== 118) begin
      failures++;
      $display("[TB] FAIL arst_long count=%0d at=%0d expected 1 at 118", longCnt[0], longAt[0]);
    end
    key[0] = 1'b1;
    stepCycles(30);
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_long_press();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
